// File: rtl/m_inv_trans.sv
// Inverse four-valued M transform: recovers operand digits from a transformed vector, DPC digits per beat.
// Optional M_INV_ERRCNT_EN: accumulate erased-digit count on err_cnt_o (tied to 0 otherwise).
module m_inv_trans #(
  parameter int P   = 33,
  parameter int DPC = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*P-1:0]         m_i,
  input  logic [1:0]             b_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*P-1:0]         a_o,
  output logic [P-1:0]           erase_o,
  output logic [$clog2(P+1)-1:0] err_cnt_o
);

  localparam int N  = (P + DPC - 1) / DPC;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(P + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic           capture, step, ready_raw;
  logic [2*P-1:0] m_q, a_q, a_nxt;
  logic [1:0]     b_q;
  logic [P-1:0]   erase_q, erase_nxt;
  logic [BW-1:0]  beat_q;
  logic [1:0]     m_d;
  int             idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_raw = 1'b0;
    capture   = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        ready_raw = 1'b1;
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (beat_q == BW'(N - 1)) state_nxt = DONE;
      end
      DONE: begin
        ready_raw = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            capture   = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset dominates readiness so no vector can be offered while the block is held in reset.
  assign in_ready  = ready_raw & rst_n;
  assign out_valid = (state == DONE);
  assign a_o       = a_q;
  assign erase_o   = erase_q;

`ifdef M_INV_ERRCNT_EN
  logic [CW-1:0] cnt_q, cnt_nxt;
`endif

  always_comb begin
    a_nxt     = a_q;
    erase_nxt = erase_q;
    m_d       = '0;
    idx       = 0;
`ifdef M_INV_ERRCNT_EN
    cnt_nxt   = cnt_q;
`endif
    for (int i = 0; i < DPC; i++) begin
      idx = int'(beat_q) * DPC + i;
      if (idx < P) begin
        m_d = m_q[2*idx +: 2];
        // odd multiplier or odd transformed digit carries no recoverable information
        if (b_q[0] | m_d[0]) begin
          a_nxt[2*idx +: 2] = 2'b01;
          erase_nxt[idx]    = 1'b1;
`ifdef M_INV_ERRCNT_EN
          cnt_nxt           = cnt_nxt + CW'(1);
`endif
        end else if (m_d[1]) begin
          a_nxt[2*idx +: 2] = b_q;
        end else begin
          a_nxt[2*idx +: 2] = {~b_q[1], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      b_q     <= '0;
      a_q     <= '0;
      erase_q <= '0;
      beat_q  <= '0;
    end else if (capture) begin
      m_q     <= m_i;
      b_q     <= b_i;
      a_q     <= '0;
      erase_q <= '0;
      beat_q  <= '0;
    end else if (step) begin
      a_q     <= a_nxt;
      erase_q <= erase_nxt;
      beat_q  <= beat_q + BW'(1);
    end
  end

`ifdef M_INV_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (capture) cnt_q <= '0;
    else if (step)    cnt_q <= cnt_nxt;
  end
  assign err_cnt_o = cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule
